mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Shares the single program/data memory port between the CPU controller-sequencer (fetch, LDA, STA, CALL/RET stack traffic) and the front-panel program loader.
- Grants one requester at a time using round-robin arbitration.
- Runs a multi-cycle memory access with a configurable number of wait states, then returns read data with a one-cycle acknowledge.
- Produces a stall signal that freezes the ring counter while a CPU access is still outstanding.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- WAIT_STATES, 1, extra access cycles after the address cycle; legal range 0..7.

Ports:
- iClk  input  1  system clock; all state changes on its rising edge.
- iReset  input  1  asynchronous, active-low reset.
- iCpuReq  input  1  CPU access request (level).
- iCpuWe  input  1  CPU request is a write.
- iCpuAddr  input  ADDR_W  CPU address.
- iCpuWdata  input  DATA_W  CPU write data.
- oCpuAck  output  1  one-cycle pulse: CPU access complete.
- oCpuStall  output  1  CPU request is pending and not yet acknowledged.
- iLdReq  input  1  loader access request (level).
- iLdWe  input  1  loader request is a write.
- iLdAddr  input  ADDR_W  loader address.
- iLdWdata  input  DATA_W  loader write data.
- oLdAck  output  1  one-cycle pulse: loader access complete.
- oRdata  output  DATA_W  captured read data (shared by both requesters).
- oMemEn  output  1  memory enable.
- oMemWe  output  1  memory write enable.
- oMemAddr  output  ADDR_W  memory address.
- oMemWdata  output  DATA_W  memory write data.
- iMemRdata  input  DATA_W  memory read data.
- oGrantCpu  output  1  CPU owns the memory port.
- oGrantLd  output  1  loader owns the memory port.
- oBusy  output  1  arbiter is not in IDLE.

Behaviour:
- Reset values (iReset low, asynchronous):
  - state = IDLE, wait counter = 0, round-robin pointer = "loader last".
  - All acks, grants, oMemEn, oMemWe = 0.
  - oMemAddr, oMemWdata, oRdata = 0.
- FSM states: IDLE, ADDR, WAIT, DONE.
- IDLE:
  - Neither request high: stay in IDLE.
  - Exactly one request high: grant that requester.
  - Both high: grant the requester not granted last. Immediately after reset the CPU wins.
  - On a grant: latch We/Addr/Wdata from the granted requester into internal registers, set the grant flag, update the pointer, go to ADDR.
- ADDR:
  - oMemEn = 1; oMemWe = latched We.
  - oMemAddr and oMemWdata driven from the latched registers.
  - WAIT_STATES = 0: go to DONE. Otherwise load the counter with WAIT_STATES and go to WAIT.
- WAIT:
  - Memory outputs held exactly as in ADDR.
  - Counter decrements each cycle; at 1, go to DONE.
- Read capture: on the last access cycle (ADDR when WAIT_STATES = 0, else the final WAIT cycle), a read registers iMemRdata into oRdata. Writes leave oRdata unchanged.
- DONE:
  - oMemEn = oMemWe = 0.
  - The ack of the granted requester is high for exactly this one cycle. Grant is still high.
  - Next state is IDLE; grants clear on leaving DONE.
- Latency: request seen in IDLE at cycle n gives ADDR at n+1 and ack at n+2+WAIT_STATES. Minimum CPU-visible turnaround is 2+WAIT_STATES cycles.
- Handshake rules:
  - Requester holds req and its payload stable until it sees ack.
  - Requester must drop req in the cycle after ack; a req still high in IDLE is a new transaction.
  - Payload changes after the grant are ignored.
- Request dropped mid-transaction: the access completes, and the ack still pulses.
- oCpuStall = iCpuReq & ~oCpuAck, combinational. It is 0 whenever iCpuReq = 0.
- oBusy = (state != IDLE).
- oGrantCpu and oGrantLd are registered, mutually exclusive, and never both high.
- Back-to-back requests from both requesters strictly alternate; neither requester is starved.
- Reset asserted mid-access: oMemEn and oMemWe drop asynchronously, and no ack is issued.

Decomposition:
- Shared package mpu_pkg holds:
  - FSM state encoding constants (IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, DONE = 2'd3).
  - MEM_ADDR_W = 16 and MEM_DATA_W = 8.
- One natural sub-module: rr_arbiter2. It takes two requests and the last-grant pointer, and returns a one-hot grant. It is combinational, with its pointer register inside the parent.

Test Plan:
- Reset, then CPU read with WAIT_STATES = 1: iCpuReq = 1, iCpuAddr = 16'h0800, memory returns 8'h3E.
  - Expect oMemEn high for 2 cycles with oMemAddr = 0800.
  - oCpuAck pulses at cycle n+3; oRdata = 8'h3E.
  - oCpuStall high for cycles n..n+2.
- Loader write: iLdWe = 1, iLdAddr = 16'h0000, iLdWdata = 8'h3E.
  - Expect oMemWe = 1 for 2 cycles with oMemWdata = 3E.
  - oLdAck pulses once; oRdata unchanged.
- Both requests held continuously from reset for 4 transactions: grant order CPU, LD, CPU, LD; ack pulses alternate; grants never overlap.
- WAIT_STATES = 0 build: CPU read of 16'h2000 returning 8'hA5 acks at n+2 with oRdata = A5.
- iReset pulled low during a WAIT cycle:
  - oMemEn drops immediately, no ack is issued, state returns to IDLE.
  - After release, a pending CPU request is served first.
- CPU drops iCpuReq during ADDR: the access still completes, oCpuAck pulses, and the FSM returns to IDLE with no second access.

Source files
------------

// File: rtl/mpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mpu_pkg : shared memory-port constants and arbiter FSM encoding      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mpu_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage : mpu_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter2 : two-way round-robin grant (bit0 = CPU, bit1 = loader) |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_arbiter2 (
  input  logic       iReqCpu,
  input  logic       iReqLd,
  input  logic       iLastLd,
  output logic [1:0] oGrant
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    oGrant = 2'b00;
    if (iReqCpu && (!iReqLd || iLastLd)) begin
      oGrant = 2'b01;
    end else if (iReqLd) begin
      oGrant = 2'b10;
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_arbiter : CPU / loader sharing of one memory port        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_access_arbiter
  import mpu_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWdata,
  output logic              oCpuAck,
  output logic              oCpuStall,
  input  logic              iLdReq,
  input  logic              iLdWe,
  input  logic [ADDR_W-1:0] iLdAddr,
  input  logic [DATA_W-1:0] iLdWdata,
  output logic              oLdAck,
  output logic [DATA_W-1:0] oRdata,
  output logic              oMemEn,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWdata,
  input  logic [DATA_W-1:0] iMemRdata,
  output logic              oGrantCpu,
  output logic              oGrantLd,
  output logic              oBusy
);

  localparam logic [2:0] c_WAIT_LOAD = 3'(WAIT_STATES);

  logic [1:0]        r_state;
  logic [2:0]        r_waitCnt;
  logic              r_lastLd;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_grantCpu;
  logic              r_grantLd;

  logic [1:0]        w_grant;
  logic              w_memActive;
  logic              w_lastCycle;

  rr_arbiter2 u_rr (
    .iReqCpu (iCpuReq),
    .iReqLd  (iLdReq),
    .iLastLd (r_lastLd),
    .oGrant  (w_grant)
  );

  assign w_memActive = (r_state == ADDR) || (r_state == WAIT);
  // Read data is only valid on the final access cycle.
  assign w_lastCycle = (WAIT_STATES == 0) ? (r_state == ADDR)
                                          : ((r_state == WAIT) && (r_waitCnt == 3'd1));

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_state    <= IDLE;
      r_waitCnt  <= 3'd0;
      r_lastLd   <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_grantCpu <= 1'b0;
      r_grantLd  <= 1'b0;
    end else begin
      if (w_lastCycle && !r_we) begin
        r_rdata <= iMemRdata;
      end
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_grantCpu <= w_grant[0];
            r_grantLd  <= w_grant[1];
            r_lastLd   <= w_grant[1];
            r_we       <= w_grant[0] ? iCpuWe    : iLdWe;
            r_addr     <= w_grant[0] ? iCpuAddr  : iLdAddr;
            r_wdata    <= w_grant[0] ? iCpuWdata : iLdWdata;
            r_state    <= ADDR;
          end
        end
        ADDR: begin
          if (WAIT_STATES == 0) begin
            r_state <= DONE;
          end else begin
            r_waitCnt <= c_WAIT_LOAD;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          r_waitCnt <= r_waitCnt - 3'd1;
          if (r_waitCnt == 3'd1) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_grantCpu <= 1'b0;
          r_grantLd  <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory strobes decode straight from state so a reset kills them at once.
  assign oMemEn    = w_memActive;
  assign oMemWe    = w_memActive & r_we;
  assign oMemAddr  = w_memActive ? r_addr  : '0;
  assign oMemWdata = w_memActive ? r_wdata : '0;

  assign oCpuAck   = (r_state == DONE) & r_grantCpu;
  assign oLdAck    = (r_state == DONE) & r_grantLd;
  assign oCpuStall = iCpuReq & ~oCpuAck;
  assign oRdata    = r_rdata;
  assign oGrantCpu = r_grantCpu;
  assign oGrantLd  = r_grantLd;
  assign oBusy     = (r_state != IDLE);

endmodule : mem_access_arbiter
`default_nettype wire

// File: tb/tb_mem_access_arbiter.sv
`default_nettype none
// Bench for mem_access_arbiter: transaction-level reference model plus
// directed scenarios on a WAIT_STATES=1 instance and a WAIT_STATES=0 instance.
module tb_mem_access_arbiter;

  localparam int WS = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, mem_init;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [15:0] cpu_addr, ld_addr;
  logic [7:0]  cpu_wdata, ld_wdata;
  logic        cpu_ack, cpu_stall, ld_ack, mem_en, mem_we, gc, gl, busy;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        c0_req;
  logic [15:0] c0_addr;
  logic        a0_cack, a0_stall, a0_lack, a0_en, a0_we, a0_gc, a0_gl, a0_busy;
  logic [7:0]  a0_rdata, a0_wdata;
  logic [15:0] a0_addr;

  int n_chk = 0;
  int n_pass = 0;

  mem_access_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(WS)) u_dut (
    .iClk(clk), .iReset(rst_n),
    .iCpuReq(cpu_req), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr), .iCpuWdata(cpu_wdata),
    .oCpuAck(cpu_ack), .oCpuStall(cpu_stall),
    .iLdReq(ld_req), .iLdWe(ld_we), .iLdAddr(ld_addr), .iLdWdata(ld_wdata),
    .oLdAck(ld_ack), .oRdata(rdata),
    .oMemEn(mem_en), .oMemWe(mem_we), .oMemAddr(mem_addr), .oMemWdata(mem_wdata),
    .iMemRdata(mem_rdata), .oGrantCpu(gc), .oGrantLd(gl), .oBusy(busy)
  );

  mem_access_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(0)) u_dut0 (
    .iClk(clk), .iReset(rst_n),
    .iCpuReq(c0_req), .iCpuWe(1'b0), .iCpuAddr(c0_addr), .iCpuWdata(8'h00),
    .oCpuAck(a0_cack), .oCpuStall(a0_stall),
    .iLdReq(1'b0), .iLdWe(1'b0), .iLdAddr(16'h0000), .iLdWdata(8'h00),
    .oLdAck(a0_lack), .oRdata(a0_rdata),
    .oMemEn(a0_en), .oMemWe(a0_we), .oMemAddr(a0_addr), .oMemWdata(a0_wdata),
    .iMemRdata(8'hA5), .oGrantCpu(a0_gc), .oGrantLd(a0_gl), .oBusy(a0_busy)
  );

  function automatic logic [7:0] init_val(input int i);
    return (i == 0) ? 8'h3E : 8'(i * 37 + 5);
  endfunction

  // Memory device seen by the main instance (256-byte image, low address bits).
  logic [7:0] dev_mem [256];
  assign mem_rdata = dev_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      dev_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a transaction occupies cycles k = 1 .. 2+WS after the
  // IDLE cycle that accepted it; memory is driven for k <= 1+WS, ack at 2+WS.
  int          m_k;
  bit          m_own, m_lastLd, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic [7:0]  model_mem [256];

  task automatic model_reset();
    m_k = 0; m_own = 0; m_lastLd = 1; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    if (m_k == 0) begin
      if (cpu_req || ld_req) begin
        if (cpu_req && ld_req) m_own = m_lastLd ? 1'b0 : 1'b1;
        else                   m_own = ld_req;
        m_lastLd = m_own;
        m_we    = m_own ? ld_we    : cpu_we;
        m_addr  = m_own ? ld_addr  : cpu_addr;
        m_wdata = m_own ? ld_wdata : cpu_wdata;
        m_k = 1;
      end
    end else begin
      if (m_k == 1 + WS) begin
        if (m_we) model_mem[m_addr[7:0]] = m_wdata;
        else      m_rdata = model_mem[m_addr[7:0]];
      end
      if (m_k == 2 + WS) m_k = 0;
      else               m_k++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit e_en, e_ack;
        e_en  = (m_k >= 1) && (m_k <= 1 + WS);
        e_ack = (m_k == 2 + WS);
        chk("ctrl{en,we,cack,lack,gc,gl,busy,stall}",
            {24'd0, mem_en, mem_we, cpu_ack, ld_ack, gc, gl, busy, cpu_stall},
            {24'd0, e_en, e_en & m_we, e_ack & !m_own, e_ack & m_own,
             (m_k != 0) & !m_own, (m_k != 0) & m_own, m_k != 0,
             cpu_req & ~(e_ack & !m_own)});
        if (e_en) begin
          chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
          if (m_we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
        end
        chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit who, output bit seen);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (who ? ld_ack : cpu_ack) seen = 1;
    end
  endtask

  task automatic requester(input bit who, input int n);
    for (int t = 0; t < n; t++) begin
      bit seen, dropnow, early;
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) drive_edge();
      early = ($urandom_range(0, 3) == 0);
      if (who) begin
        ld_req = 1; ld_we = $urandom_range(0, 1) == 1;
        ld_addr = 16'($urandom); ld_wdata = 8'($urandom);
      end else begin
        cpu_req = 1; cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
      end
      seen = 0; dropnow = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (who ? ld_ack : cpu_ack) seen = 1;
        else if (early && (who ? gl : gc)) dropnow = 1;
        @(posedge clk); #1;
        if (seen || dropnow) begin
          if (who) ld_req = 0; else cpu_req = 0;
        end
      end
      chk(who ? "ld_ack_timeout" : "cpu_ack_timeout", {31'd0, seen}, 32'd1);
    end
  endtask

  initial begin
    logic [3:0] en_h, ack_h, st_h, we_h, ord;
    logic [15:0] a1;
    logic [7:0]  w1;
    logic [2:0]  e0, k0;
    bit seen;
    int nack, ovl, en_cnt;

    rst_n = 0; mem_init = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    c0_req = 0; c0_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {24'd0, mem_en, mem_we, cpu_ack, ld_ack, gc, gl, busy, 1'b0}, 32'd0);
    chk("reset_bus", {mem_addr, mem_wdata, rdata}, 32'd0);
    drive_edge(); rst_n = 1; mem_init = 0;
    drive_edge();

    // CPU read of 0x0800, memory image returns 0x3E.
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0800;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en_h[i] = mem_en; ack_h[i] = cpu_ack; st_h[i] = cpu_stall;
      if (i == 1) a1 = mem_addr;
    end
    drive_edge(); cpu_req = 0;
    chk("rd_en_cycles", {28'd0, en_h}, 32'b0110);
    chk("rd_ack_cycle", {28'd0, ack_h}, 32'b1000);
    chk("rd_stall_cycles", {28'd0, st_h}, 32'b0111);
    chk("rd_addr", {16'd0, a1}, 32'h0800);
    @(negedge clk);
    chk("rd_data", {24'd0, rdata}, 32'h3E);
    chk("model_rd_pin", {24'd0, m_rdata}, 32'h3E);

    // Loader write of 0x3E to 0x0000.
    drive_edge();
    ld_req = 1; ld_we = 1; ld_addr = 16'h0000; ld_wdata = 8'h3E;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      we_h[i] = mem_we; ack_h[i] = ld_ack;
      if (i == 1) w1 = mem_wdata;
    end
    drive_edge(); ld_req = 0; ld_we = 0;
    chk("wr_we_cycles", {28'd0, we_h}, 32'b0110);
    chk("wr_ack_cycle", {28'd0, ack_h}, 32'b1000);
    chk("wr_wdata", {24'd0, w1}, 32'h3E);
    @(negedge clk);
    chk("wr_rdata_kept", {24'd0, rdata}, 32'h3E);

    // Both requesters held continuously: strict alternation.
    drive_edge();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0020; ld_wdata = 8'h5A;
    nack = 0; ovl = 0; ord = 0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(negedge clk);
      if (gc && gl) ovl++;
      if (cpu_ack || ld_ack) begin
        ord[nack] = ld_ack;
        nack++;
      end
    end
    drive_edge(); cpu_req = 0; ld_req = 0; ld_we = 0;
    chk("alt_count", nack, 4);
    chk("alt_order", {28'd0, ord}, 32'b1010);
    chk("alt_overlap", ovl, 0);

    // Reset pulled during the WAIT cycle, loader also requesting afterwards.
    drive_edge();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0800;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_en", {30'd0, mem_en, mem_we}, 32'd0);
    chk("rst_mid_state", {28'd0, busy, gc, cpu_ack, ld_ack}, 32'd0);
    ld_req = 1; ld_we = 0; ld_addr = 16'h0044;
    @(negedge clk); #2 rst_n = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (gc || gl) seen = 1;
    end
    chk("post_rst_first_grant", {30'd0, gc, gl}, 32'b10);
    wait_ack(0, seen);
    chk("post_rst_cpu_ack", {31'd0, seen}, 32'd1);
    drive_edge(); cpu_req = 0;
    wait_ack(1, seen);
    chk("post_rst_ld_ack", {31'd0, seen}, 32'd1);
    drive_edge(); ld_req = 0;

    // CPU drops its request during ADDR.
    drive_edge();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0033;
    @(posedge clk); #1;
    chk("drop_grant", {31'd0, gc}, 32'd1);
    cpu_req = 0;
    wait_ack(0, seen);
    chk("drop_ack", {31'd0, seen}, 32'd1);
    en_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_en || busy) en_cnt++;
    end
    chk("drop_no_second", en_cnt, 0);

    // Randomised traffic from both requesters.
    fork
      requester(0, 30);
      requester(1, 30);
    join

    // WAIT_STATES = 0 instance: read of 0x2000 returns 0xA5 at n+2.
    drive_edge();
    c0_req = 1; c0_addr = 16'h2000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e0[i] = a0_en; k0[i] = a0_cack;
    end
    drive_edge(); c0_req = 0;
    chk("ws0_en_cycles", {29'd0, e0}, 32'b010);
    chk("ws0_ack_cycle", {29'd0, k0}, 32'b100);
    chk("ws0_rdata", {24'd0, a0_rdata}, 32'hA5);
    repeat (3) @(negedge clk);
    chk("ws0_idle", {29'd0, a0_busy, a0_gc, a0_gl}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_access_arbiter
`default_nettype wire
